// File: rtl/result_frame_pkg.sv
// rtl/result_frame_pkg.sv - shared types and widths for the result frame packer
package result_frame_pkg;

  localparam int BYTE_W        = 8;
  localparam int FRAME_COUNT_W = 16;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
    logic [BYTE_W-1:0] cksum;
  } frame_entry_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0
  } wr_state_t;

endpackage

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - generic first-word-fall-through FIFO with full-with-pop acceptance
module frame_fifo #(
  parameter type entry_t = logic [16:0],
  parameter int  DEPTH   = 16,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop_req,
  output logic             accept,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop;
  entry_t           mem [DEPTH];

  assign pop    = (count != '0) & pop_req;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign accept = push & ((count < CNT_W'(DEPTH)) | pop);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(accept) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/result_frame_packer.sv
// rtl/result_frame_packer.sv - frames the result byte stream, appends checksums, buffers for the host sink
module result_frame_packer
  import result_frame_pkg::*;
#(
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic [BYTE_W-1:0]        out_data,
  output logic [BYTE_W-1:0]        out_cksum,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output logic [FRAME_COUNT_W-1:0] frame_count
);

  localparam int              BCNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(FRAME_LEN - 1);
  localparam int              FCNT_W   = $clog2(FIFO_DEPTH) + 1;

  wr_state_t                state, state_nxt;
  logic [BCNT_W-1:0]        byte_cnt, byte_cnt_nxt;
  logic [BYTE_W-1:0]        sum, sum_nxt;
  logic [FRAME_COUNT_W-1:0] frame_count_nxt;
  logic                     overflow_nxt;
  logic                     accept;
  frame_entry_t             wr_entry;
  frame_entry_t             head;
  logic [FCNT_W-1:0]        fifo_count;

  frame_fifo #(
    .entry_t (frame_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_valid),
    .push_entry (wr_entry),
    .pop_req    (out_ready),
    .accept     (accept),
    .head       (head),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= COLLECT;
      byte_cnt    <= '0;
      sum         <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= byte_cnt_nxt;
      sum         <= sum_nxt;
      frame_count <= frame_count_nxt;
      overflow    <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    byte_cnt_nxt    = byte_cnt;
    sum_nxt         = sum;
    frame_count_nxt = frame_count;
    wr_entry.last   = 1'b0;
    wr_entry.data   = in_data;
    wr_entry.cksum  = '0;
    case (state)
      COLLECT: begin
        // Dropped bytes leave the frame position untouched.
        if (accept) begin
          if (byte_cnt == LAST_IDX) begin
            wr_entry.last   = 1'b1;
            wr_entry.cksum  = sum + in_data;
            sum_nxt         = '0;
            byte_cnt_nxt    = '0;
            frame_count_nxt = frame_count + 1'b1;
          end else begin
            sum_nxt      = sum + in_data;
            byte_cnt_nxt = byte_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // A drop in the same cycle as clear_ovf keeps the flag set.
  assign overflow_nxt = (in_valid & ~accept) | (overflow & ~clear_ovf);

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid & head.last;
  assign out_cksum = (out_valid & head.last) ? head.cksum : '0;

endmodule

// File: tb/tb_result_frame_packer.sv
// tb/tb_result_frame_packer.sv - scoreboard bench for result_frame_packer against a frame-level model
module tb_result_frame_packer;

  localparam int FL    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic       last;
    logic [7:0] data;
    logic [7:0] cksum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic [7:0]  out_cksum;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clear_ovf;
  logic [15:0] frame_count;

  logic [7:0]  in1_data;
  logic        in1_valid;
  logic [7:0]  out1_data;
  logic [7:0]  out1_cksum;
  logic        out1_last;
  logic        out1_valid;
  logic        out1_ready;
  logic        overflow1;
  logic        clear1;
  logic [15:0] frame_count1;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [7:0]  frame_q[$];
  int          cur_count = 0;
  logic        cur_ovf = 1'b0;
  logic [15:0] cur_fc = 16'h0;
  exp_t        mon_e;

  always #5 clk = ~clk;

  result_frame_packer #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_cksum(out_cksum), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .clear_ovf(clear_ovf), .frame_count(frame_count)
  );

  result_frame_packer #(.FRAME_LEN(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in1_data), .in_valid(in1_valid),
    .out_data(out1_data), .out_cksum(out1_cksum), .out_last(out1_last),
    .out_valid(out1_valid), .out_ready(out1_ready), .overflow(overflow1),
    .clear_ovf(clear1), .frame_count(frame_count1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic        pop;
    logic        acc;
    logic [7:0]  s;
    logic        nxt_ovf;
    logic [15:0] nxt_fc;
    int          nxt_count;
    exp_t        e;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear_ovf = c;
    pop    = (cur_count > 0) && r;
    acc    = v && ((cur_count < DEPTH) || pop);
    nxt_fc = cur_fc;
    if (acc) begin
      s = d;
      foreach (frame_q[i]) s = s + frame_q[i];
      e.data = d;
      if (frame_q.size() + 1 == FL) begin
        e.last  = 1'b1;
        e.cksum = s;
        frame_q.delete();
        nxt_fc = cur_fc + 16'd1;
      end else begin
        e.last  = 1'b0;
        e.cksum = 8'h00;
        frame_q.push_back(d);
      end
      exp_q.push_back(e);
    end
    nxt_count = cur_count + (acc ? 1 : 0) - (pop ? 1 : 0);
    nxt_ovf   = (v && !acc) ? 1'b1 : (c ? 1'b0 : cur_ovf);
    @(posedge clk);
    #1;
    cur_count = nxt_count;
    cur_ovf   = nxt_ovf;
    cur_fc    = nxt_fc;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    exp_q.delete();
    frame_q.delete();
    cur_count = 0;
    cur_ovf   = 1'b0;
    cur_fc    = 16'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", {31'b0, out_valid}, {31'b0, cur_count != 0});
      chk("overflow", {31'b0, overflow}, {31'b0, cur_ovf});
      chk("frame_count", {16'b0, frame_count}, {16'b0, cur_fc});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", {31'b0, out_valid}, 32'h0);
        end else begin
          mon_e = exp_q[0];
          chk("out_data", {24'b0, out_data}, {24'b0, mon_e.data});
          chk("out_last", {31'b0, out_last}, {31'b0, mon_e.last});
          chk("out_cksum", {24'b0, out_cksum}, {24'b0, mon_e.cksum});
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_outputs", {15'b0, out_data, out_cksum, out_last}, 32'h0);
      end
    end
  end

  initial begin
    logic [7:0] seq_a[8];
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clear_ovf = 1'b0;
    in1_valid = 1'b0; in1_data = 8'h00; out1_ready = 1'b0; clear1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // FRAME_LEN=1 instance: every byte closes its own frame.
    in1_valid = 1'b1; in1_data = 8'h7E;
    @(posedge clk); #1;
    in1_data = 8'h81;
    @(posedge clk); #1;
    in1_valid = 1'b0;
    chk("fl1_valid", {31'b0, out1_valid}, 32'h1);
    chk("fl1_data0", {24'b0, out1_data}, 32'h7E);
    chk("fl1_last0", {31'b0, out1_last}, 32'h1);
    chk("fl1_cksum0", {24'b0, out1_cksum}, 32'h7E);
    chk("fl1_frames", {16'b0, frame_count1}, 32'h2);
    out1_ready = 1'b1;
    @(posedge clk); #1;
    out1_ready = 1'b0;
    chk("fl1_data1", {24'b0, out1_data}, 32'h81);
    chk("fl1_last1", {31'b0, out1_last}, 32'h1);
    chk("fl1_cksum1", {24'b0, out1_cksum}, 32'h81);

    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("frames_after_first", {16'b0, frame_count}, 32'h1);

    seq_a = '{8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h10, 8'h20, 8'h30, 8'h40};
    foreach (seq_a[i]) cycle(1'b1, seq_a[i], 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("ovf_after_17", {31'b0, overflow}, 32'h1);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    chk("ovf_set_wins", {31'b0, overflow}, 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", {31'b0, overflow}, 32'h0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_with_pop_no_ovf", {31'b0, overflow}, 32'h0);
    repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    cycle(1'b1, 8'h05, 1'b1, 1'b0);
    cycle(1'b1, 8'h06, 1'b1, 1'b0);
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("frames_after_reset", {16'b0, frame_count}, 32'h1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 7) == 0));
      end
    end

    repeat (40) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
